// File: rtl/cmn_fifo_arb.sv
// cmn_fifo_arb
// Round-robin arbiter that shares one cmn_fifo write port among N packet
// requesters. Each requester presents a valid/ready/last stream. One
// requester is granted at a time. The grant is held until the packet ends
// or MAXB beats have been written. Every written word carries the source ID
// in its MSBs. The FIFO is never written while it reports full.
//
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   req_valid  [N]       per-requester beat valid
//   req_data   [N*DW]    requester i payload at [i*DW +: DW]
//   req_last   [N]       per-requester last beat of packet
//   req_ready  [N]       per-requester beat accepted
//   fifo_we              FIFO write enable
//   fifo_wdata [DW+IW]   {source ID, payload}
//   fifo_full            FIFO full flag
//   busy                 a grant is active
//   gnt_id     [IW]      currently / last granted requester
module cmn_fifo_arb #(
  parameter int N    = 4,
  parameter int DW   = 32,
  parameter int MAXB = 8,
  parameter int IW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DW-1:0]   req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  output logic              fifo_we,
  output logic [DW+IW-1:0]  fifo_wdata,
  input  logic              fifo_full,
  output logic              busy,
  output logic [IW-1:0]     gnt_id
);

  localparam int            CW       = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(MAXB - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [CW-1:0] beat_cnt;

  logic          sel_valid;
  logic          sel_last;
  logic [DW-1:0] sel_data;
  logic          any_valid;
  logic [IW-1:0] pick;
  logic [IW-1:0] next_ptr;
  logic          beat;
  logic          rel_beat;

  // Route the granted requester's valid/last/data onto single wires so
  // that the rest of the logic does not need variable part-selects.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin pick: among the valid requesters, take the one with the
  // smallest forward distance from rr_ptr (mod N). This is the first valid
  // requester in the order rr_ptr, rr_ptr+1, ...
  always_comb begin
    int best_d;
    int d;
    best_d    = N;
    d         = 0;
    pick      = '0;
    any_valid = |req_valid;
    for (int i = 0; i < N; i++) begin
      if (req_valid[i]) begin
        d = (i - int'(rr_ptr) + N) % N;
        if (d < best_d) begin
          best_d = d;
          pick   = IW'(i);
        end
      end
    end
  end

  // Pointer after the current grant, wrapping N-1 back to 0. This also
  // covers the case where N is not a power of two.
  assign next_ptr = (gnt_id == IW'(N - 1)) ? '0 : gnt_id + IW'(1);

  // A beat moves only while granted, with the owner valid and FIFO room.
  // The grant ends on the owner's last beat or on the MAXB-th beat.
  assign beat     = (state == BUSY) && sel_valid && !fifo_full;
  assign rel_beat = beat && (sel_last || (beat_cnt == LAST_CNT));
  assign fifo_we  = beat;

  // Only the owner sees ready, and only when the FIFO can take a word.
  // Nothing leaves the arbiter while idle, or while reset holds it idle.
  always_comb begin
    req_ready  = '0;
    fifo_wdata = '0;
    if (state == BUSY) begin
      for (int i = 0; i < N; i++) begin
        if (gnt_id == IW'(i)) req_ready[i] = !fifo_full;
      end
      fifo_wdata = {gnt_id, sel_data};
    end
  end

  // Grant FSM. IDLE always costs one cycle to register the arbitration
  // result. BUSY counts accepted beats and returns to IDLE on release,
  // advancing the round-robin pointer past the requester just served.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            gnt_id   <= pick;
            beat_cnt <= '0;
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (beat) beat_cnt <= beat_cnt + CW'(1);
          if (rel_beat) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmn_fifo_arb.sv
// Self-checking bench for cmn_fifo_arb. The requesters are modelled as
// per-requester packet queues. A transaction-level reference (owner, beats
// taken in the grant, round-robin pointer) predicts the arbiter outputs for
// every cycle.
module tb_cmn_fifo_arb;

  localparam int N    = 4;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int IW   = 2;
  localparam int WW   = DW + IW;
  localparam int VW   = 1 + IW + N + 1 + WW;
  localparam int QD   = 512;

  logic             clk = 1'b0;
  logic             rstn;
  logic [N-1:0]     req_valid;
  logic [N*DW-1:0]  req_data;
  logic [N-1:0]     req_last;
  logic [N-1:0]     req_ready;
  logic             fifo_we;
  logic [WW-1:0]    fifo_wdata;
  logic             fifo_full;
  logic             busy;
  logic [IW-1:0]    gnt_id;

  cmn_fifo_arb #(.N(N), .DW(DW), .MAXB(MAXB)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready),
    .fifo_we(fifo_we), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
    .busy(busy), .gnt_id(gnt_id)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Requester packet queues: {last, data}, circular with head/tail counters.
  logic [DW:0] pk_mem [N][QD];
  int          pk_head [N];
  int          pk_tail [N];
  logic [N-1:0] en;
  logic         tb_full;

  // Reference model state.
  bit m_busy;
  int m_gnt, m_cnt, m_ptr;
  logic           exp_we;
  logic [VW-1:0]  exp_vec, obs_vec;

  task automatic push_pkt(input int r, input int len, input logic [DW-1:0] base);
    for (int k = 0; k < len; k++) begin
      pk_mem[r][pk_tail[r] % QD] = {(k == len - 1), base + DW'(k)};
      pk_tail[r]++;
    end
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (pk_head[i] != pk_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (en[i] && pk_head[i] < pk_tail[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = pk_mem[i][pk_head[i] % QD][DW-1:0];
        req_last[i]           = pk_mem[i][pk_head[i] % QD][DW];
      end else begin
        req_valid[i]          = 1'b0;
        req_data[i*DW +: DW]  = $urandom;
        req_last[i]           = 1'($urandom_range(0, 1));
      end
    end
    fifo_full = tb_full;
  endtask

  task automatic predict();
    logic [N-1:0]  rdy;
    logic [WW-1:0] wd;
    rdy    = '0;
    wd     = '0;
    exp_we = m_busy && req_valid[m_gnt] && !fifo_full;
    if (m_busy && !fifo_full) rdy[m_gnt] = 1'b1;
    if (exp_we) wd = {IW'(m_gnt), req_data[m_gnt*DW +: DW]};
    exp_vec = {m_busy, IW'(m_gnt), rdy, exp_we, wd};
  endtask

  function automatic logic [VW-1:0] observe();
    return {busy, gnt_id, req_ready, fifo_we, fifo_we ? fifo_wdata : WW'(0)};
  endfunction

  // Advance the reference by one clock: a beat pops the owner's queue and
  // may end the grant; an idle cycle with any request starts a new grant.
  task automatic advance();
    logic l;
    if (exp_we) begin
      l = req_last[m_gnt];
      pk_head[m_gnt]++;
      m_cnt++;
      if (l || m_cnt == MAXB) begin
        m_busy = 1'b0;
        m_ptr  = (m_gnt + 1) % N;
      end
    end else if (!m_busy && req_valid != '0) begin
      for (int d = N - 1; d >= 0; d--)
        if (req_valid[(m_ptr + d) % N]) m_gnt = (m_ptr + d) % N;
      m_cnt  = 0;
      m_busy = 1'b1;
    end
  endtask

  task automatic cycle_begin();
    drive_inputs();
    @(negedge clk);
    predict();
    obs_vec = observe();
  endtask

  task automatic cycle_end();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn    = 1'b0;
    en      = '1;
    tb_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      pk_head[i] = 0;
      pk_tail[i] = 0;
    end
    m_busy = 1'b0; m_gnt = 0; m_cnt = 0; m_ptr = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = '1;
    fifo_full = 1'b0;
    #1;
    n_checks++;
    if ({busy, gnt_id, req_ready, fifo_we, fifo_wdata} !== '0)
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {busy, gnt_id, req_ready, fifo_we, fifo_wdata});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single();
    logic [WW-1:0] wlog [8];
    int nw, first_tag;
    bit drained;
    nw = 0; drained = 0; first_tag = -1;
    do_reset();
    push_pkt(2, 3, 32'hA0);
    for (int c = 0; c < 12 && !drained; c++) begin
      cycle_begin();
      if (fifo_we && nw < 8) begin wlog[nw] = fifo_wdata; nw++; end
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL single c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (nw !== 3) $display("[TB] FAIL single_count: got %0d want 3", nw); else n_pass++;
    for (int k = 0; k < 3 && k < nw; k++) begin
      n_checks++;
      if (wlog[k] !== {2'd2, 32'hA0 + 32'(k)})
        $display("[TB] FAIL single_word%0d: got %h want %h", k, wlog[k], {2'd2, 32'hA0 + 32'(k)});
      else n_pass++;
    end
    // Pointer now sits at 3: with 0 and 3 both requesting, 3 goes first.
    push_pkt(0, 1, 32'hB0);
    push_pkt(3, 1, 32'hB3);
    drained = 0;
    for (int c = 0; c < 12 && !drained; c++) begin
      cycle_begin();
      if (fifo_we && first_tag < 0) first_tag = int'(fifo_wdata[WW-1:DW]);
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL single_ptr c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (first_tag !== 3) $display("[TB] FAIL single_rrptr: got %0d want 3", first_tag); else n_pass++;
  endtask

  task automatic test_rr();
    int tags [6];
    int wcyc [6];
    int nw;
    bit drained;
    int exp_tags [6];
    exp_tags = '{0, 1, 2, 3, 0, 1};
    nw = 0; drained = 0;
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < N; i++) push_pkt(i, 1, DW'(i * 16 + k));
    for (int c = 0; c < 60 && !drained; c++) begin
      cycle_begin();
      if (fifo_we && nw < 6) begin tags[nw] = int'(fifo_wdata[WW-1:DW]); wcyc[nw] = c; nw++; end
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL rr c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (!drained) $display("[TB] FAIL rr_timeout: got busy/pending want drained"); else n_pass++;
    for (int k = 0; k < 6 && k < nw; k++) begin
      n_checks++;
      if (tags[k] !== exp_tags[k]) $display("[TB] FAIL rr_order%0d: got %0d want %0d", k, tags[k], exp_tags[k]);
      else n_pass++;
      if (k > 0) begin
        n_checks++;
        if (wcyc[k] - wcyc[k-1] !== 2)
          $display("[TB] FAIL rr_spacing%0d: got %0d want 2", k, wcyc[k] - wcyc[k-1]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_maxb();
    int ctag [8];
    int clen [8];
    int nch;
    bit new_grant, drained;
    int exp_tag [4];
    int exp_len [4];
    exp_tag = '{1, 3, 1, 1};
    exp_len = '{8, 5, 8, 4};
    nch = 0; new_grant = 1; drained = 0;
    do_reset();
    push_pkt(1, 20, 32'h100);
    push_pkt(3, 5, 32'h300);
    for (int c = 0; c < 120 && !drained; c++) begin
      cycle_begin();
      if (!busy) new_grant = 1;
      if (fifo_we && nch < 8) begin
        if (new_grant) begin
          ctag[nch] = int'(fifo_wdata[WW-1:DW]); clen[nch] = 0; nch++; new_grant = 0;
        end
        clen[nch-1]++;
      end
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL maxb c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (nch !== 4) $display("[TB] FAIL maxb_chunks: got %0d want 4", nch); else n_pass++;
    for (int k = 0; k < 4 && k < nch; k++) begin
      n_checks++;
      if (ctag[k] !== exp_tag[k] || clen[k] !== exp_len[k])
        $display("[TB] FAIL maxb_chunk%0d: got id%0d x%0d want id%0d x%0d",
                 k, ctag[k], clen[k], exp_tag[k], exp_len[k]);
      else n_pass++;
    end
  endtask

  task automatic test_full();
    logic [DW-1:0] dlog [8];
    int nw, full_left;
    bit armed, drained;
    nw = 0; full_left = 0; armed = 0; drained = 0;
    do_reset();
    push_pkt(0, 4, 32'h400);
    for (int c = 0; c < 40 && !drained; c++) begin
      tb_full = (full_left > 0);
      cycle_begin();
      if (fifo_we && nw < 8) begin dlog[nw] = fifo_wdata[DW-1:0]; nw++; end
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL full c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      if (tb_full) begin
        n_checks++;
        if (fifo_we !== 1'b0 || req_ready !== '0)
          $display("[TB] FAIL full_stall c%0d: got we=%b ready=%b want 0/0", c, fifo_we, req_ready);
        else n_pass++;
      end
      cycle_end();
      if (full_left > 0) full_left--;
      if (nw == 2 && !armed) begin full_left = 5; armed = 1; end
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (nw !== 4) $display("[TB] FAIL full_count: got %0d want 4", nw); else n_pass++;
    for (int k = 0; k < 4 && k < nw; k++) begin
      n_checks++;
      if (dlog[k] !== 32'h400 + 32'(k)) $display("[TB] FAIL full_word%0d: got %h want %h", k, dlog[k], 32'h400 + 32'(k));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int n0_before, nw0, off_left;
    bit seen2, armed, drained;
    n0_before = 0; nw0 = 0; off_left = 0; seen2 = 0; armed = 0; drained = 0;
    do_reset();
    push_pkt(0, 6, 32'h500);
    push_pkt(2, 3, 32'h520);
    for (int c = 0; c < 60 && !drained; c++) begin
      en[0] = !(off_left > 0);
      cycle_begin();
      if (fifo_we) begin
        if (fifo_wdata[WW-1:DW] == 2'd2) seen2 = 1;
        else if (!seen2) n0_before++;
      end
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL stall c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      if (exp_we && m_gnt == 0) nw0++;
      cycle_end();
      if (off_left > 0) off_left--;
      if (nw0 == 2 && !armed) begin off_left = 3; armed = 1; end
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (n0_before !== 6) $display("[TB] FAIL stall_order: got %0d want 6", n0_before); else n_pass++;
  endtask

  task automatic test_async_reset();
    int nw, first_tag;
    bit drained;
    nw = 0; first_tag = -1; drained = 0;
    do_reset();
    push_pkt(1, 5, 32'h600);
    for (int c = 0; c < 20 && nw < 2; c++) begin
      cycle_begin();
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL areset c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      if (exp_we) nw++;
      cycle_end();
    end
    cycle_begin();
    n_checks++;
    if (obs_vec !== exp_vec) $display("[TB] FAIL areset_beat3: got %h want %h", obs_vec, exp_vec);
    else n_pass++;
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0) $display("[TB] FAIL areset_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (fifo_we !== 1'b0) $display("[TB] FAIL areset_we: got %b want 0", fifo_we); else n_pass++;
    n_checks++;
    if (req_ready !== '0) $display("[TB] FAIL areset_ready: got %b want 0", req_ready); else n_pass++;
    do_reset();
    for (int i = N - 1; i >= 0; i--) push_pkt(i, 1, 32'h700 + DW'(i));
    for (int c = 0; c < 30 && !drained; c++) begin
      cycle_begin();
      if (fifo_we && first_tag < 0) first_tag = int'(fifo_wdata[WW-1:DW]);
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL areset_after c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (first_tag !== 0) $display("[TB] FAIL areset_restart: got %0d want 0", first_tag); else n_pass++;
  endtask

  task automatic test_random();
    bit drained;
    drained = 0;
    do_reset();
    for (int p = 0; p < 6; p++)
      for (int i = 0; i < N; i++)
        push_pkt(i, int'($urandom_range(1, 12)), $urandom);
    for (int c = 0; c < 3000 && !drained; c++) begin
      tb_full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 4) != 0);
      cycle_begin();
      n_checks++;
      if (obs_vec !== exp_vec) $display("[TB] FAIL random c%0d: got %h want %h", c, obs_vec, exp_vec);
      else n_pass++;
      cycle_end();
      drained = !m_busy && queues_empty();
    end
    n_checks++;
    if (!drained) $display("[TB] FAIL random_timeout: got pending want drained"); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_maxb();
    test_full();
    test_stall();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
